// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a main/skid register pair for full throughput under backpressure.
// Optional RV32M decode is enabled by defining RV32M_EN.
module decode_stage #(
    parameter int                      ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [31:0]             instruction,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] pc_out,
    output logic [6:0]              opcode,
    output logic [6:0]              funct7,
    output logic [2:0]              funct3,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              rd,
    output logic [31:0]             imm32,
    output logic                    wEn,
    output logic                    branch_op,
    output logic                    mem_wEn,
    output logic                    wb_sel,
    output logic                    op_B_sel,
    output logic [1:0]              op_A_sel,
    output logic [5:0]              ALU_Control,
    output logic [1:0]              MemSize,
    output logic                    illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [6:0]              opcode;
        logic [6:0]              funct7;
        logic [2:0]              funct3;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic [31:0]             imm;
        logic                    wen;
        logic                    br;
        logic                    mwen;
        logic                    wb;
        logic                    opb;
        logic [1:0]              opa;
        logic [5:0]              alu;
        logic [1:0]              msize;
        logic                    ill;
    } bundle_t;

    function automatic bundle_t decode(input logic [31:0] ins, input logic [ADDRESS_BITS-1:0] pc);
        bundle_t    b;
        logic [2:0] f3;
        logic [6:0] f7;
        b        = '0;
        f3       = ins[14:12];
        f7       = ins[31:25];
        b.pc     = pc;
        b.opcode = ins[6:0];
        b.funct7 = f7;
        b.funct3 = f3;
        b.rs1    = ins[19:15];
        b.rs2    = ins[24:20];
        b.rd     = ins[11:7];
        case (ins[6:0])
            OPC_OP: begin
                b.wen = 1'b1;
                // Bit 30 only distinguishes SUB from ADD and SRA from SRL.
                if (f7 == 7'b0000000 || f7 == 7'b0100000)
                    b.alu = {2'b00, (ins[30] && (f3 == 3'b000 || f3 == 3'b101)), f3};
`ifdef RV32M_EN
                else if (f7 == 7'b0000001)
                    b.alu = {3'b100, f3};
`endif
                else
                    b.ill = 1'b1;
            end
            OPC_OP_IMM: begin
                b.wen = 1'b1;
                b.opb = 1'b1;
                b.imm = {{20{ins[31]}}, ins[31:20]};
                b.alu = {2'b00, (ins[30] && f3 == 3'b101), f3};
            end
            OPC_LOAD: begin
                b.wen   = 1'b1;
                b.wb    = 1'b1;
                b.opb   = 1'b1;
                b.imm   = {{20{ins[31]}}, ins[31:20]};
                b.msize = f3[1:0];
                b.ill   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                b.mwen  = 1'b1;
                b.opb   = 1'b1;
                b.imm   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                b.msize = f3[1:0];
                b.ill   = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                b.br  = 1'b1;
                b.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                b.alu = {3'b010, f3};
                b.ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LUI: begin
                b.wen = 1'b1;
                b.opb = 1'b1;
                b.opa = 2'b11;
                b.imm = {ins[31:12], 12'h000};
            end
            OPC_AUIPC: begin
                b.wen = 1'b1;
                b.opb = 1'b1;
                b.opa = 2'b01;
                b.imm = {ins[31:12], 12'h000};
            end
            OPC_JAL: begin
                b.wen = 1'b1;
                b.opb = 1'b1;
                b.opa = 2'b10;
                b.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                b.alu = 6'b011111;
            end
            OPC_JALR: begin
                b.wen = 1'b1;
                b.opb = 1'b1;
                b.opa = 2'b10;
                b.imm = {{20{ins[31]}}, ins[31:20]};
                b.alu = 6'b111111;
            end
            default: b.ill = 1'b1;
        endcase
        // Illegal instructions still flow through but must not change architectural state.
        if (b.ill) begin
            b.wen  = 1'b0;
            b.mwen = 1'b0;
            b.br   = 1'b0;
            b.alu  = 6'b000000;
        end
        return b;
    endfunction

    bundle_t dec_p0;
    bundle_t skid_p0;
    bundle_t main_p1;
    logic    vld_p0;
    logic    vld_p1;
    logic    accept;

    assign dec_p0   = decode(instruction, PC);
    assign in_ready = !vld_p0 && reset_n;
    assign accept   = in_valid && in_ready;

    // Stage boundary: decoded bundle lands in main, or in skid when main is stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            skid_p0    <= '0;
            main_p1    <= '0;
            main_p1.pc <= RESET_PC;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (vld_p0) begin
            if (out_ready) begin
                main_p1 <= skid_p0;
                vld_p0  <= 1'b0;
            end
        end else if (accept) begin
            if (!vld_p1 || out_ready) begin
                main_p1 <= dec_p0;
                vld_p1  <= 1'b1;
            end else begin
                skid_p0 <= dec_p0;
                vld_p0  <= 1'b1;
            end
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign pc_out      = main_p1.pc;
    assign opcode      = main_p1.opcode;
    assign funct7      = main_p1.funct7;
    assign funct3      = main_p1.funct3;
    assign read_sel1   = main_p1.rs1;
    assign read_sel2   = main_p1.rs2;
    assign rd          = main_p1.rd;
    assign imm32       = main_p1.imm;
    assign wEn         = main_p1.wen;
    assign branch_op   = main_p1.br;
    assign mem_wEn     = main_p1.mwen;
    assign wb_sel      = main_p1.wb;
    assign op_B_sel    = main_p1.opb;
    assign op_A_sel    = main_p1.opa;
    assign ALU_Control = main_p1.alu;
    assign MemSize     = main_p1.msize;
    assign illegal     = main_p1.ill;

endmodule
